// File: rtl/fsqrt_pkg.sv
// fsqrt_pkg: shared types and IEEE constants for the square-root unit
package fsqrt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        MUL_T,
        MUL_U,
        MUL_Y,
        MUL_S,
        PACK,
        DONE
    } fsqrt_state_t;

    typedef enum logic {
        MODE_RSQRT = 1'b0,
        MODE_SQRT  = 1'b1
    } fsqrt_mode_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP_PINF = 32'h7F800000;
    localparam int          FP_BIAS = 127;

endpackage

// File: rtl/rsqrt_seed.sv
// rsqrt_seed: elaboration-time ROM of 1/sqrt(a) at each bin midpoint, Q1.(TBL_BITS+1)
module rsqrt_seed
    import fsqrt_pkg::*;
#(
    parameter int TBL_BITS = 10
) (
    input  logic [TBL_BITS:0]   idx,
    output logic [TBL_BITS+1:0] seed
);

    localparam int N = 2 ** (TBL_BITS + 1);

    // idx[TBL_BITS]=1 means odd exponent (a in [1,2)), else a in [2,4)
    function automatic logic [TBL_BITS+1:0] seed_val(input int i);
        longint d, n, r, c, one;
        one = 64'(1) << (TBL_BITS + 1);
        d = one + 2 * longint'(i % (2 ** TBL_BITS)) + 1;
        d = (i >= 2 ** TBL_BITS) ? d : 2 * d;
        n = (64'(1) << (3 * TBL_BITS + 5)) / d;
        r = 0;
        for (int b = TBL_BITS + 3; b >= 0; b--) begin
            c = r + (64'(1) << b);
            if (c * c <= n) r = c;
        end
        r = (r + 1) >> 1;
        r = (r > one) ? one : r;
        return (TBL_BITS + 2)'(r);
    endfunction

    logic [TBL_BITS+1:0] rom [N];

    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam logic [TBL_BITS+1:0] V = seed_val(i);
        assign rom[i] = V;
    end

    assign seed = rom[idx];

endmodule

// File: rtl/fsqrt_iter.sv
// fsqrt_iter: multi-cycle binary32 sqrt / rsqrt via seed ROM and Newton-Raphson steps
module fsqrt_iter
    import fsqrt_pkg::*;
#(
    parameter int TBL_BITS = 10,
    parameter int ITER     = 2,
    parameter int W        = 28
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y
);

    localparam int CW = (ITER > 0) ? $clog2(ITER + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((ITER > 0) ? ITER - 1 : 0);
    localparam logic [W+1:0]  THREE = {2'b11, {W{1'b0}}};

    fsqrt_state_t        state;
    fsqrt_mode_t         md;
    logic [30:0]         xr;
    logic [CW-1:0]       cnt;
    logic [W+1:0]        a, y, p;
    logic [W+1:0]        op1, op2, pw, a_dec, seed_y;
    logic [2*W+3:0]      prod;
    logic [TBL_BITS+1:0] seed;
    logic [7:0]          ie, ea, rs_x, sq_x;
    logic [22:0]         im;
    logic [9:0]          rs_e, sq_e;
    logic                is_nan, is_zero, is_inf, special;
    logic [31:0]         spec_y, pack_y;

    rsqrt_seed #(.TBL_BITS(TBL_BITS)) u_seed (
        .idx  ({xr[23], xr[22 -: TBL_BITS]}),
        .seed (seed)
    );

    assign in_ready = (state == IDLE);

    assign ie      = in_x[30:23];
    assign im      = in_x[22:0];
    assign is_nan  = (&ie) && (|im);
    assign is_inf  = (&ie) && !(|im);
    assign is_zero = (ie == 8'd0);
    assign special = is_nan || is_inf || is_zero || in_x[31];
    assign spec_y  = is_nan    ? FP_QNAN :
                     is_zero   ? (in_mode ? {in_x[31], 31'b0} : FP_PINF) :
                     in_x[31]  ? FP_QNAN :
                     (in_mode ? FP_PINF : 32'h0);

    assign a_dec  = xr[23] ? {2'b01, xr[22:0], {(W-23){1'b0}}} : {1'b1, xr[22:0], {(W-22){1'b0}}};
    assign seed_y = (W+2)'(seed) << (W - TBL_BITS - 1);

    assign op1  = (state == MUL_U || state == MUL_S) ? a : y;
    assign op2  = (state == MUL_U) ? p : (state == MUL_Y) ? THREE - p : y;
    assign prod = (2*W+4)'(op1) * (2*W+4)'(op2);
    assign pw   = (W+2)'(prod >> W);

    // Odd-adjusted exponent makes k' even, so both result exponents halve exactly
    assign ea   = xr[23] ? xr[30:23] : xr[30:23] - 8'd1;
    assign rs_e = 10'(3 * FP_BIAS) - {2'b0, ea};
    assign sq_e = 10'(FP_BIAS) + {2'b0, ea};
    assign rs_x = 8'(rs_e >> 1);
    assign sq_x = 8'(sq_e >> 1);
    // s can fall just below 1.0 when a is exactly 1 or 2^2n; renormalise instead of wrapping
    assign pack_y = (md == MODE_SQRT) ?
                    (p[W] ? {1'b0, sq_x, 23'(p >> (W - 23))} : {1'b0, sq_x - 8'd1, 23'(p >> (W - 24))}) :
                    (y[W] ? {1'b0, rs_x, 23'b0} : {1'b0, rs_x - 8'd1, 23'(y >> (W - 24))});

    // Control FSM and datapath registers; one shared multiply per MUL_* state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            md        <= MODE_RSQRT;
            xr        <= '0;
            cnt       <= '0;
            a         <= '0;
            y         <= '0;
            p         <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xr <= in_x[30:0];
                    md <= fsqrt_mode_t'(in_mode);
                    if (special) begin
                        out_y     <= spec_y;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= SEED;
                    end
                end
                SEED: begin
                    a     <= a_dec;
                    y     <= seed_y;
                    cnt   <= '0;
                    state <= (ITER > 0) ? MUL_T : ((md == MODE_SQRT) ? MUL_S : PACK);
                end
                MUL_T: begin
                    p     <= pw;
                    state <= MUL_U;
                end
                MUL_U: begin
                    p     <= pw;
                    state <= MUL_Y;
                end
                MUL_Y: begin
                    y     <= pw >> 1;
                    cnt   <= cnt + CW'(1);
                    state <= (cnt < LAST) ? MUL_T : ((md == MODE_SQRT) ? MUL_S : PACK);
                end
                MUL_S: begin
                    p     <= pw;
                    state <= PACK;
                end
                PACK: begin
                    out_y     <= pack_y;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsqrt_iter.sv
// tb_fsqrt_iter: directed and swept checks of fsqrt_iter at default parameters
module tb_fsqrt_iter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_y;

    int checks = 0;
    int errors = 0;

    fsqrt_iter u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Snaps an in-tolerance value onto the reference so check() can compare exactly
    function automatic logic [31:0] near(input logic [31:0] g, input logic [31:0] e, input int tol);
        logic [31:0] d;
        d = (g > e) ? g - e : e - g;
        return (d <= 32'(tol)) ? e : g;
    endfunction

    function automatic real f2r(input logic [31:0] x);
        return $bitstoreal({x[31], 11'({3'b0, x[30:23]} + 11'd896), x[22:0], 29'b0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        b = $realtobits(r);
        return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    endfunction

    task automatic op(input logic [31:0] x, input logic m, output logic [31:0] y, output int lat);
        @(negedge clk);
        in_x = x;
        in_mode = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = out_y;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] x;
        logic        m;
        logic [31:0] e;
        int          tol;
        int          lat;
    } vec_t;

    vec_t vecs[$] = '{
        '{32'h40800000, 1'b0, 32'h3F000000, 2, 8},
        '{32'h40000000, 1'b1, 32'h3FB504F3, 2, 9},
        '{32'h41100000, 1'b1, 32'h40400000, 2, 9},
        '{32'h40800000, 1'b1, 32'h40000000, 2, 9},
        '{32'h3E800000, 1'b1, 32'h3F000000, 2, 9},
        '{32'h40000000, 1'b0, 32'h3F3504F3, 2, 8},
        '{32'h3F000000, 1'b0, 32'h3FB504F3, 2, 8},
        '{32'hBF800000, 1'b1, 32'h7FC00000, 0, 0},
        '{32'h00000000, 1'b0, 32'h7F800000, 0, 0},
        '{32'h80000000, 1'b1, 32'h80000000, 0, 0},
        '{32'h7F800000, 1'b0, 32'h00000000, 0, 0},
        '{32'h7F800000, 1'b1, 32'h7F800000, 0, 0},
        '{32'h7FC00001, 1'b1, 32'h7FC00000, 0, 0}
    };

    initial begin
        logic [31:0] y, x;
        int          lat, hits;
        real         v, r;

        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_y", out_y, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            op(vecs[i].x, vecs[i].m, y, lat);
            check($sformatf("val_%0d", i), near(y, vecs[i].e, vecs[i].tol), vecs[i].e);
            check($sformatf("lat_%0d", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result must hold and stray in_valid pulses must be ignored
        @(negedge clk);
        in_x = 32'h41800000;
        in_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_x = 32'h40800000;
            @(posedge clk);
            #1;
            check("bp_hold", near(out_y, 32'h3E800000, 2), 32'h3E800000);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_drop", 32'(out_valid), 32'd0);
        check("bp_idle", 32'(in_ready), 32'd1);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            hits += int'(out_valid);
        end
        check("bp_no_second", 32'(hits), 32'd0);

        // Reset while in MUL_U of the first Newton step
        @(negedge clk);
        in_x = 32'h40800000;
        in_mode = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_busy", 32'(in_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check("mid_valid", 32'(out_valid), 32'd0);
        check("mid_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            hits += int'(out_valid);
        end
        check("mid_no_result", 32'(hits), 32'd0);
        op(32'h41800000, 1'b0, y, lat);
        check("post_rst_val", near(y, 32'h3E800000, 2), 32'h3E800000);
        check("post_rst_lat", 32'(lat), 32'd8);

        // Sweep of positive normals in both modes against a real-number model
        for (int i = 0; i < 400; i++) begin
            x = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            v = f2r(x);
            r = i[0] ? $sqrt(v) : 1.0 / $sqrt(v);
            op(x, i[0], y, lat);
            check($sformatf("sweep_%h_m%0d", x, i[0]), near(y, r2f(r), 2), r2f(r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
